// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Iterative signed integer divider (restoring algorithm, one
//             quotient bit per clock) with a start/done handshake. Flags use
//             the same 3-bit layout as the ALU: {negative, overflow, zero}.
//  Revision : 1.0 - initial release
//
//  Ports
//    clk    in   1      rising-edge clock
//    rst_n  in   1      asynchronous active-low reset
//    start  in   1      request, sampled only in IDLE
//    a      in   WIDTH  signed dividend
//    b      in   WIDTH  signed divisor
//    busy   out  1      high while the divide is in progress (CALC/FIX)
//    done   out  1      one-cycle pulse, q/r/d valid
//    q      out  WIDTH  signed quotient (truncated toward zero)
//    r      out  WIDTH  signed remainder (sign follows dividend)
//    d      out  3      {negative, overflow, zero}
//
//  Optional build macro
//    DIV_EARLY_TERM_EN : when |a| < |b| the result (q=0, r=a) is produced
//                        straight from IDLE, done one cycle after acceptance.
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic [2:0]       d
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Working registers
    logic [WIDTH-1:0] rem;      // partial remainder (magnitude)
    logic [WIDTH-1:0] quo;      // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] b_abs;
    logic             neg_q;
    logic             neg_r;
    logic             ovf;
    logic [CW-1:0]    cnt;

    // Operand magnitudes; the most-negative value maps onto itself, which is
    // the correct unsigned magnitude.
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             b_zero;
    logic             early;

    assign a_mag  = a[WIDTH-1] ? ('0 - a) : a;
    assign b_mag  = b[WIDTH-1] ? ('0 - b) : b;
    assign b_zero = (b == '0);

`ifdef DIV_EARLY_TERM_EN
    assign early = (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    // One restoring step. The shifted remainder needs WIDTH+1 bits, but when
    // the subtraction succeeds the result is below |b| so WIDTH bits suffice.
    logic [WIDTH:0]   sh;
    logic             ge;
    logic [WIDTH-1:0] rem_nxt;

    assign sh      = {rem, quo[WIDTH-1]};
    assign ge      = (sh >= {1'b0, b_abs});
    assign rem_nxt = ge ? (sh[WIDTH-1:0] - b_abs) : sh[WIDTH-1:0];

    // Final sign correction
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign q_fix = neg_q ? ('0 - quo) : quo;
    assign r_fix = neg_r ? ('0 - rem) : rem;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (b_zero || early) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem   <= '0;
            quo   <= '0;
            b_abs <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            ovf   <= 1'b0;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            d     <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rem   <= '0;
                        quo   <= a_mag;
                        b_abs <= b_mag;
                        neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        neg_r <= a[WIDTH-1];
                        ovf   <= (a == MOST_NEG) && (b == '1);
                        cnt   <= CW'(WIDTH - 1);
                        // Short paths publish their result right away
                        if (b_zero) begin
                            q <= '1;
                            r <= a;
                            d <= 3'b110;
                        end else if (early) begin
                            q <= '0;
                            r <= a;
                            d <= 3'b001;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    quo <= {quo[WIDTH-2:0], ge};
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    q <= q_fix;
                    r <= r_fix;
                    d <= {q_fix[WIDTH-1], ovf, (q_fix == '0)};
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_divider
//  Purpose  : Self-checking bench for seq_divider (WIDTH=32). An arithmetic
//             reference model predicts acceptance, latency and results; a
//             per-cycle compare process checks busy/done/q/r/d against it,
//             and directed cases pin literal values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int W = 32;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  a     = '0;
    logic [W-1:0]  b     = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic [2:0]    d;

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .d     (d)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference arithmetic: plain signed division on 64-bit integers
    // ------------------------------------------------------------------
    function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] y,
                                    output logic [W-1:0] qq, output logic [W-1:0] rr,
                                    output logic [2:0] dd, output int lat);
        longint sx, sy, sq, sr, ax, ay;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ax  = (sx < 0) ? -sx : sx;
        ay  = (sy < 0) ? -sy : sy;
        lat = W + 2;
        if (sy == 0) begin
            qq  = '1;
            rr  = x;
            dd  = 3'b110;
            lat = 1;
        end else begin
            sq = sx / sy;
            sr = sx % sy;
            qq = sq[W-1:0];
            rr = sr[W-1:0];
            dd = {qq[W-1], (sx == -64'sd2147483648) && (sy == -64'sd1), (qq == '0)};
`ifdef DIV_EARLY_TERM_EN
            if (ax < ay) lat = 1;
`else
            if (ax < ay) lat = W + 2;
`endif
        end
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: when an op is accepted, when its result appears,
    // and what the held outputs are.
    // ------------------------------------------------------------------
    bit           m_active = 1'b0;
    int           m_cyc    = 0;
    int           m_acc    = 0;
    int           m_lat    = 1;
    logic [W-1:0] m_q = '0, m_r = '0, m_nq = '0, m_nr = '0;
    logic [2:0]   m_d = '0, m_nd = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active = 1'b0;
                m_q      = '0;
                m_r      = '0;
                m_d      = '0;
            end else begin
                m_cyc++;
                // Idle means no op, or the done cycle of the last op is over
                if (!m_active || (m_cyc - m_acc > m_lat)) begin
                    if (start) begin
                        ref_div(a, b, m_nq, m_nr, m_nd, m_lat);
                        m_acc    = m_cyc;
                        m_active = 1'b1;
                    end
                end
                if (m_active && (m_cyc - m_acc == m_lat - 1)) begin
                    m_q = m_nq;
                    m_r = m_nr;
                    m_d = m_nd;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the model
    // ------------------------------------------------------------------
    int j;
    bit e_busy, e_done;
    initial begin
        forever begin
            @(negedge clk);
            j      = m_cyc - m_acc;
            e_busy = m_active && (j < m_lat - 1);
            e_done = m_active && (j == m_lat - 1);
            chk("cyc_busy", busy, e_busy);
            chk("cyc_done", done, e_done);
            if (!e_busy) begin
                chk("cyc_q", q, m_q);
                chk("cyc_r", r, m_r);
                chk("cyc_d", d, m_d);
            end
        end
    end

    // ------------------------------------------------------------------
    // One operation. Entered #1 after a posedge in an idle cycle; returns
    // #1 after the posedge that ends the done cycle.
    //   poke  : re-pulse start with other operands while busy
    //   dpoke : pulse start during the done cycle
    // ------------------------------------------------------------------
    task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input int exp_lat, input logic [W-1:0] eq,
                          input logic [W-1:0] er, input logic [2:0] ed,
                          input bit poke, input bit dpoke);
        int n;
        n     = 0;
        a     = aa;
        b     = bb;
        start = 1'b1;
        do begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) start = 1'b0;
            if (poke && n == 5) begin
                start = 1'b1;
                a     = ~aa;
                b     = bb + 32'd3;
            end
            if (poke && n == 6) start = 1'b0;
        end while (!done && n < 100);
        chk("done_seen", done, 1'b1);
        chk("latency", n, exp_lat);
        chk("res_q", q, eq);
        chk("res_r", r, er);
        chk("res_d", d, ed);
        if (dpoke) begin
            start = 1'b1;
            a     = 32'd5;
            b     = 32'd1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        if (dpoke) chk("start_in_done_ignored", busy, 1'b0);
    endtask

    task automatic run_rand(input logic [W-1:0] aa, input logic [W-1:0] bb);
        logic [W-1:0] eq, er;
        logic [2:0]   ed;
        int           lat;
        ref_div(aa, bb, eq, er, ed, lat);
        run_op(aa, bb, lat, eq, er, ed, 1'b0, 1'b0);
    endtask

    int lat_small;
    logic [W-1:0] ra, rb;

    initial begin
        #5000000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
`ifdef DIV_EARLY_TERM_EN
        lat_small = 1;
`else
        lat_small = W + 2;
`endif
        // Reset state
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_q", q, 32'h0);
        chk("rst_r", r, 32'h0);
        chk("rst_d", d, 3'b000);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Signed basics; first one also re-pulses start while busy
        run_op(32'd100, 32'd7, 34, 32'd14, 32'd2, 3'b000, 1'b1, 1'b0);
        run_op(-32'sd100, 32'd7, 34, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 3'b100, 1'b0, 1'b0);
        // Results hold across idle cycles
        repeat (3) @(posedge clk);
        #1;
        chk("hold_q", q, 32'hFFFF_FFF2);
        chk("hold_r", r, 32'hFFFF_FFFE);
        run_op(32'd100, -32'sd7, 34, 32'hFFFF_FFF2, 32'd2, 3'b100, 1'b0, 1'b1);
        // Back-to-back: start in the cycle right after done
        run_op(32'd55, 32'd0, 1, 32'hFFFF_FFFF, 32'd55, 3'b110, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000, 32'd0, 3'b110, 1'b0, 1'b0);
        run_op(32'd3, 32'd9, lat_small, 32'd0, 32'd3, 3'b001, 1'b0, 1'b0);
        run_op(-32'sd3, 32'd9, lat_small, 32'd0, -32'sd3, 3'b001, 1'b0, 1'b0);
        run_op(32'd1000, 32'd3, 34, 32'd333, 32'd1, 3'b000, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a division
        a     = 32'd12345;
        b     = 32'd17;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_q", q, 32'h0);
        chk("mid_rst_r", r, 32'h0);
        chk("mid_rst_d", d, 3'b000);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(32'd9, 32'd3, 34, 32'd3, 32'd0, 3'b000, 1'b0, 1'b0);

        // Randomised operands with a mix of corner classes
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : rb; end
                2: rb = $urandom_range(1, 20);
                3: rb = -$urandom_range(1, 20);
                4: ra = $urandom_range(0, 50);
                5: rb = 32'h8000_0000;
                default: ;
            endcase
            run_rand(ra, rb);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
